alu_instr_sequencer: RTL and testbench

- Parametrised control sequencer that generates, cycle by cycle, the datapath control strobes for fetch and for register-to-register ALU instructions.
- It decodes the instruction register (IR), steps through T-states, and waits on a memory-ready and an ALU-done handshake.
- It sits between the datapath and the future top-level CPU, and replaces the hand-scripted T0–T5 control sequences used so far.

---
 rtl/alu_instr_sequencer.sv | 256 +++++++++++++++++++++++++
 tb/tb_alu_instr_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_instr_sequencer.sv
// alu_instr_sequencer
//   Moore control sequencer for instruction fetch and register-to-register
//   ALU instructions. It walks T-states, decodes IR at the end of T2 and
//   drives one-hot datapath strobes from the registered state and latched
//   decode only.
//
//   Optional feature: define SEQ_MULDIV_EN to build the MUL/DIV path
//   (state T6, HIin/LOin/Zhighout, alu_done wait). Without it, MUL/DIV
//   opcodes are illegal and alu_done is ignored.
//
//   Ports
//     Clock, reset      rising-edge clock, async active-low reset
//     run               keep fetching/executing while high
//     mem_rdy           memory read complete (sampled in T1)
//     alu_done          multi-cycle ALU result valid (sampled in MUL/DIV T4)
//     IRVal             instruction register contents
//     PCout..LOin       single-bit datapath strobes
//     GPRin, GPRout     one-hot register write/read selects
//     alu_op            one-hot ALU op: ADD,SUB,MUL,DIV,SHR,SHL,ROR,ROL,
//                       AND,OR,NEGATE,NOT (bit 0 = ADD)
//     busy/done/illegal status; state = debug view of the state register
module alu_instr_sequencer #(
   parameter int BITS      = 32,
   parameter int REGISTERS = 16
) (
   input  logic                 Clock,
   input  logic                 reset,
   input  logic                 run,
   input  logic                 mem_rdy,
   input  logic                 alu_done,
   input  logic [BITS-1:0]      IRVal,
   output logic                 PCout,
   output logic                 MARin,
   output logic                 IncPC,
   output logic                 RZin,
   output logic                 Read,
   output logic                 PCin,
   output logic                 MDRin,
   output logic                 IRin,
   output logic                 MDRout,
   output logic                 RYin,
   output logic                 Zlowout,
   output logic                 Zhighout,
   output logic                 HIin,
   output logic                 LOin,
   output logic [REGISTERS-1:0] GPRin,
   output logic [REGISTERS-1:0] GPRout,
   output logic [11:0]          alu_op,
   output logic                 busy,
   output logic                 done,
   output logic                 illegal,
   output logic [3:0]           state
);

   typedef enum logic [3:0] {
      S_IDLE = 4'd0,
      S_T0   = 4'd1,
      S_T1   = 4'd2,
      S_T2   = 4'd3,
      S_T3   = 4'd4,
      S_T4   = 4'd5,
      S_T5   = 4'd6,
`ifdef SEQ_MULDIV_EN
      S_T6   = 4'd7,
`endif
      S_ILL  = 4'd8
   } state_t;

   typedef enum logic [1:0] {
      K_3R = 2'd0,   // Ra <- Rb op Rc
      K_MD = 2'd1,   // HI:LO <- Ra op Rb
      K_UN = 2'd2    // Ra <- op Rb
   } kind_t;

   localparam logic [4:0]           NREG = 5'(REGISTERS);
   localparam logic [REGISTERS-1:0] ONE  = REGISTERS'(1);

   state_t      state_q, state_d;
   kind_t       kind_q, kind_d;
   logic [3:0]  ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
   logic [11:0] op_q, op_d;

   // IR field decode, only consumed while in T2
   logic [4:0]  opc;
   logic [3:0]  ir_ra, ir_rb, ir_rc;
   logic [11:0] dec_op;
   kind_t       dec_kind;
   logic        dec_ok, use_rc, legal;

`ifdef SEQ_MULDIV_EN
   logic unused_ir;
   assign unused_ir = ^IRVal[14:0];
`else
   logic unused_in;
   assign unused_in = ^{IRVal[14:0], alu_done};
`endif

   assign opc   = IRVal[31:27];
   assign ir_ra = IRVal[26:23];
   assign ir_rb = IRVal[22:19];
   assign ir_rc = IRVal[18:15];

   always_comb begin
      dec_op   = '0;
      dec_kind = K_3R;
      dec_ok   = 1'b1;
      use_rc   = 1'b0;
      case (opc)
         5'd3:  begin dec_op = 12'h001; use_rc = 1'b1; end  // ADD
         5'd4:  begin dec_op = 12'h002; use_rc = 1'b1; end  // SUB
         5'd5:  begin dec_op = 12'h010; use_rc = 1'b1; end  // SHR
         5'd6:  begin dec_op = 12'h020; use_rc = 1'b1; end  // SHL
         5'd7:  begin dec_op = 12'h040; use_rc = 1'b1; end  // ROR
         5'd8:  begin dec_op = 12'h080; use_rc = 1'b1; end  // ROL
         5'd9:  begin dec_op = 12'h100; use_rc = 1'b1; end  // AND
         5'd10: begin dec_op = 12'h200; use_rc = 1'b1; end  // OR
`ifdef SEQ_MULDIV_EN
         5'd14: begin dec_op = 12'h004; dec_kind = K_MD; end
         5'd15: begin dec_op = 12'h008; dec_kind = K_MD; end
`endif
         5'd16: begin dec_op = 12'h400; dec_kind = K_UN; end
         5'd17: begin dec_op = 12'h800; dec_kind = K_UN; end
         default: dec_ok = 1'b0;
      endcase
      // Rc only matters for the three-register form
      legal = dec_ok && ({1'b0, ir_ra} < NREG) && ({1'b0, ir_rb} < NREG)
              && (!use_rc || ({1'b0, ir_rc} < NREG));
   end

   // Decode is captured on the T2 exit edge and then held, so IR may change
   // freely while the instruction executes.
   always_comb begin
      kind_d = kind_q;
      ra_d   = ra_q;
      rb_d   = rb_q;
      rc_d   = rc_q;
      op_d   = op_q;
      if (state_q == S_T2 && legal) begin
         kind_d = dec_kind;
         ra_d   = ir_ra;
         rb_d   = ir_rb;
         rc_d   = ir_rc;
         op_d   = dec_op;
      end
   end

   always_ff @(posedge Clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         kind_q  <= K_3R;
         ra_q    <= '0;
         rb_q    <= '0;
         rc_q    <= '0;
         op_q    <= '0;
      end else begin
         state_q <= state_d;
         kind_q  <= kind_d;
         ra_q    <= ra_d;
         rb_q    <= rb_d;
         rc_q    <= rc_d;
         op_q    <= op_d;
      end
   end

   // Next state and Moore outputs
   always_comb begin
      state_d  = state_q;
      PCout    = 1'b0;
      MARin    = 1'b0;
      IncPC    = 1'b0;
      RZin     = 1'b0;
      Read     = 1'b0;
      PCin     = 1'b0;
      MDRin    = 1'b0;
      IRin     = 1'b0;
      MDRout   = 1'b0;
      RYin     = 1'b0;
      Zlowout  = 1'b0;
      Zhighout = 1'b0;
      HIin     = 1'b0;
      LOin     = 1'b0;
      GPRin    = '0;
      GPRout   = '0;
      alu_op   = '0;
      done     = 1'b0;
      illegal  = 1'b0;
      busy     = (state_q != S_IDLE);
      state    = state_q;
      case (state_q)
         S_IDLE: if (run) state_d = S_T0;
         S_T0: begin
            PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; RZin = 1'b1;
            state_d = S_T1;
         end
         S_T1: begin
            Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
            if (mem_rdy) state_d = S_T2;
         end
         S_T2: begin
            MDRout = 1'b1; IRin = 1'b1;
            state_d = legal ? S_T3 : S_ILL;
         end
         S_T3: begin
            GPRout  = ONE << ((kind_q == K_MD) ? ra_q : rb_q);
            state_d = S_T4;
            if (kind_q == K_UN) begin
               alu_op = op_q; RZin = 1'b1;
            end else begin
               RYin = 1'b1;
            end
         end
         S_T4: begin
            if (kind_q == K_UN) begin
               Zlowout = 1'b1; GPRin = ONE << ra_q; done = 1'b1;
               state_d = run ? S_T0 : S_IDLE;
            end else begin
               GPRout = ONE << ((kind_q == K_MD) ? rb_q : rc_q);
               alu_op = op_q; RZin = 1'b1;
               if (kind_q == K_3R) state_d = S_T5;
`ifdef SEQ_MULDIV_EN
               else if (alu_done) state_d = S_T5;
`endif
            end
         end
         S_T5: begin
            Zlowout = 1'b1;
`ifdef SEQ_MULDIV_EN
            if (kind_q == K_MD) begin
               LOin = 1'b1; state_d = S_T6;
            end else begin
               GPRin = ONE << ra_q; done = 1'b1;
               state_d = run ? S_T0 : S_IDLE;
            end
`else
            GPRin = ONE << ra_q; done = 1'b1;
            state_d = run ? S_T0 : S_IDLE;
`endif
         end
`ifdef SEQ_MULDIV_EN
         S_T6: begin
            Zhighout = 1'b1; HIin = 1'b1; done = 1'b1;
            state_d = run ? S_T0 : S_IDLE;
         end
`endif
         S_ILL: begin
            illegal = 1'b1;
            state_d = run ? S_T0 : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
`ifndef SEQ_MULDIV_EN
      alu_op[3:2] = 2'b00;
`endif
   end

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Scoreboard bench for alu_instr_sequencer. For every instruction issued
// the reference model lays out the full per-cycle control word sequence
// (and the per-cycle handshake inputs that go with it); the words are queued
// and a negedge monitor pops one per busy cycle and compares.
module tb_alu_instr_sequencer;
   localparam int REGS = 8;
`ifdef SEQ_MULDIV_EN
   localparam bit MULDIV = 1'b1;
`else
   localparam bit MULDIV = 1'b0;
`endif

   logic Clock = 1'b0, reset = 1'b0, run = 1'b0, mem_rdy = 1'b0, alu_done = 1'b0;
   logic [31:0] IRVal = '0;
   logic PCout, MARin, IncPC, RZin, Read, PCin, MDRin, IRin, MDRout, RYin;
   logic Zlowout, Zhighout, HIin, LOin, busy, done, illegal;
   logic [REGS-1:0] GPRin, GPRout;
   logic [11:0] alu_op;
   logic [3:0] state;

   alu_instr_sequencer #(.BITS(32), .REGISTERS(REGS)) dut (
      .Clock(Clock), .reset(reset), .run(run), .mem_rdy(mem_rdy),
      .alu_done(alu_done), .IRVal(IRVal),
      .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .RZin(RZin), .Read(Read),
      .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .MDRout(MDRout), .RYin(RYin),
      .Zlowout(Zlowout), .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin),
      .GPRin(GPRin), .GPRout(GPRout), .alu_op(alu_op), .busy(busy),
      .done(done), .illegal(illegal), .state(state)
   );

   always #5 Clock = ~Clock;

   typedef struct packed {
      logic busy, done, illegal;
      logic PCout, MARin, IncPC, RZin, Read, PCin, MDRin, IRin, MDRout, RYin;
      logic Zlowout, Zhighout, HIin, LOin;
      logic [REGS-1:0] gin, gout;
      logic [11:0] op;
   } ctl_t;

   ctl_t sb[$];                       // expected words, popped by the monitor
   ctl_t pw[$];                       // plan for the instruction being driven
   bit   pmr[$], pad[$], pir[$];      // per-cycle mem_rdy, alu_done, IR-valid
   int   n_cmp = 0, n_bad = 0;
   bit   at_t0 = 1'b0;

   function automatic ctl_t act();
      ctl_t a;
      a.busy = busy; a.done = done; a.illegal = illegal;
      a.PCout = PCout; a.MARin = MARin; a.IncPC = IncPC; a.RZin = RZin;
      a.Read = Read; a.PCin = PCin; a.MDRin = MDRin; a.IRin = IRin;
      a.MDRout = MDRout; a.RYin = RYin; a.Zlowout = Zlowout;
      a.Zhighout = Zhighout; a.HIin = HIin; a.LOin = LOin;
      a.gin = GPRin; a.gout = GPRout; a.op = alu_op;
      return a;
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t state=%0d)", name, got, exp, $time, state);
      end
   endtask

   task automatic add(input ctl_t w, input bit mr, input bit ad, input bit irv);
      pw.push_back(w); pmr.push_back(mr); pad.push_back(ad); pir.push_back(irv);
   endtask

   // Reference model: the control-word sequence for one instruction, given
   // the number of mem_rdy-low cycles in T1 (wm) and alu_done-low cycles (wa).
   task automatic gen(input logic [31:0] ir, input int wm, input int wa);
      ctl_t w;
      int opc, ra, rb, rc, obit;
      bit three, md, un, ok;
      pw.delete(); pmr.delete(); pad.delete(); pir.delete();
      w = '0; w.busy = 1; w.PCout = 1; w.MARin = 1; w.IncPC = 1; w.RZin = 1;
      add(w, 1'($urandom), 1'($urandom), 0);
      for (int k = 0; k <= wm; k++) begin
         w = '0; w.busy = 1; w.Zlowout = 1; w.PCin = 1; w.Read = 1; w.MDRin = 1;
         add(w, k == wm, 1'($urandom), 0);
      end
      w = '0; w.busy = 1; w.MDRout = 1; w.IRin = 1;
      add(w, 1'($urandom), 1'($urandom), 1);
      opc = int'(ir[31:27]); ra = int'(ir[26:23]); rb = int'(ir[22:19]); rc = int'(ir[18:15]);
      case (opc)
         3: obit = 0;   4: obit = 1;   5: obit = 4;   6: obit = 5;
         7: obit = 6;   8: obit = 7;   9: obit = 8;   10: obit = 9;
         14: obit = 2;  15: obit = 3;  16: obit = 10; 17: obit = 11;
         default: obit = -1;
      endcase
      three = (opc >= 3 && opc <= 10);
      md    = (opc == 14 || opc == 15) && MULDIV;
      un    = (opc == 16 || opc == 17);
      ok    = (three || md || un) && ra < REGS && rb < REGS && (!three || rc < REGS);
      if (!ok) begin
         w = '0; w.busy = 1; w.illegal = 1;
         add(w, 1'($urandom), 1'($urandom), 0);
      end else if (three) begin
         w = '0; w.busy = 1; w.gout = REGS'(1) << rb; w.RYin = 1;
         add(w, 1'($urandom), 1'($urandom), 0);
         w = '0; w.busy = 1; w.gout = REGS'(1) << rc; w.op = 12'(1) << obit; w.RZin = 1;
         add(w, 1'($urandom), 1'($urandom), 0);
         w = '0; w.busy = 1; w.Zlowout = 1; w.gin = REGS'(1) << ra; w.done = 1;
         add(w, 1'($urandom), 1'($urandom), 0);
      end else if (md) begin
         w = '0; w.busy = 1; w.gout = REGS'(1) << ra; w.RYin = 1;
         add(w, 1'($urandom), 1'($urandom), 0);
         for (int k = 0; k <= wa; k++) begin
            w = '0; w.busy = 1; w.gout = REGS'(1) << rb; w.op = 12'(1) << obit; w.RZin = 1;
            add(w, 1'($urandom), k == wa, 0);
         end
         w = '0; w.busy = 1; w.Zlowout = 1; w.LOin = 1;
         add(w, 1'($urandom), 1'($urandom), 0);
         w = '0; w.busy = 1; w.Zhighout = 1; w.HIin = 1; w.done = 1;
         add(w, 1'($urandom), 1'($urandom), 0);
      end else begin
         w = '0; w.busy = 1; w.gout = REGS'(1) << rb; w.op = 12'(1) << obit; w.RZin = 1;
         add(w, 1'($urandom), 1'($urandom), 0);
         w = '0; w.busy = 1; w.Zlowout = 1; w.gin = REGS'(1) << ra; w.done = 1;
         add(w, 1'($urandom), 1'($urandom), 0);
      end
   endtask

   // Drive one instruction in lockstep with its plan. run is random except
   // in the final cycle, where cont decides between back-to-back and IDLE.
   // abort pulls reset low during the first T4 cycle.
   task automatic issue(input logic [31:0] ir, input int wm, input int wa,
                        input bit cont, input bit abort);
      bit stop;
      if (!at_t0) begin
         repeat ($urandom_range(0, 2)) begin
            run = 0; mem_rdy = 1'($urandom); alu_done = 1'($urandom); IRVal = $urandom;
            @(posedge Clock); #1;
         end
         run = 1;
         @(posedge Clock); #1;
      end
      gen(ir, wm, wa);
      foreach (pw[i]) sb.push_back(pw[i]);
      stop = 0;
      for (int i = 0; i < pw.size() && !stop; i++) begin
         mem_rdy  = pmr[i];
         alu_done = pad[i];
         IRVal    = pir[i] ? ir : $urandom;
         run      = (i == pw.size() - 1) ? cont : 1'($urandom);
         if (abort && i == wm + 4) begin
            #2 reset = 0;
            #1;
            check("rst_outs", 64'(act()), 64'd0);
            check("rst_state", 64'(state), 64'd0);
            sb.delete();
            @(posedge Clock); #1;
            reset = 1;
            stop = 1;
         end else begin
            @(posedge Clock); #1;
         end
      end
      at_t0 = cont && !abort;
   endtask

   always @(negedge Clock) begin
      ctl_t e;
      if (busy) begin
         if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL sb_empty: DUT busy (state=%0d) with no expected cycle", state);
         end else begin
            e = sb.pop_front();
            check("ctl", 64'(act()), 64'(e));
         end
      end else begin
         check("idle_outs", 64'(act()), 64'd0);
         check("idle_state", 64'(state), 64'd0);
      end
   end

   initial begin
      logic [31:0] ir, ir_bad_ra;
      int opsel;
      int legal_ops[12] = '{3, 4, 5, 6, 7, 8, 9, 10, 14, 15, 16, 17};
      #1;
      check("reset_outs", 64'(act()), 64'd0);
      check("reset_state", 64'(state), 64'd0);
      repeat (3) @(posedge Clock);
      #1 reset = 1;

      ir_bad_ra = (32'h4A920000 & ~(32'hF << 23)) | (32'd12 << 23);
      issue(32'h4A920000, 0, 0, 1, 0);   // AND R5 <- R2 & R4
      issue(32'h4A920000, 3, 0, 0, 0);   // same with 3 memory wait cycles
      issue(32'h71880000, 0, 4, 1, 0);   // MUL (illegal without MUL/DIV)
      issue(32'h83B00000, 1, 0, 1, 0);   // NEG R7 <- -R6
      issue(32'h00000000, 0, 0, 1, 0);   // unsupported opcode
      issue(ir_bad_ra, 0, 0, 0, 0);      // Ra = 12 with 8 registers
      issue(32'h4A920000, 0, 0, 1, 1);   // reset during T4
      issue(32'h4A920000, 0, 0, 1, 0);   // refetch after reset

      for (int n = 0; n < 200; n++) begin
         opsel = int'($urandom_range(0, 9));
         ir = $urandom;
         if (opsel < 8) ir[31:27] = 5'(legal_ops[$urandom_range(0, 11)]);
         ir[26:23] = 4'($urandom_range(0, 9));
         ir[22:19] = 4'($urandom_range(0, 9));
         ir[18:15] = 4'($urandom_range(0, 9));
         issue(ir, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               1'($urandom), 0);
      end

      issue(32'h83B00000, 0, 0, 0, 0);
      run = 0;
      repeat (3) begin @(posedge Clock); #1; end
      check("sb_drain", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
